// File: rtl/run_expander.sv
// Run-length expander: (value, count) pairs become a byte stream, optionally packed into a frame buffer.
// Buffer logic is compiled only when RUN_EXPANDER_PACK_EN is defined; otherwise out_arr/out_len/overflow read 0.
module run_expander #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_value,
    input  logic [3:0]     in_count,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_data,
    output logic           out_last,
    output logic [8*N-1:0] out_arr,
    output logic [7:0]     out_len,
    output logic           done,
    output logic           overflow
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] value_reg;
    logic [3:0] count_reg;
    logic       last_reg;
    logic       accept;
    logic       xfer;

    assign accept = in_valid && (state_reg == IDLE);
    assign xfer   = out_ready && (state_reg == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (in_count != 4'd0) begin
                        state_next = EMIT;
                    end else if (in_last) begin
                        state_next = DONE;
                    end
                end
            end
            EMIT: begin
                if (out_ready && count_reg == 4'd1) begin
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Zero-count pairs never enter EMIT, so the latched run is left untouched for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= 8'd0;
            count_reg <= 4'd0;
            last_reg  <= 1'b0;
        end else if (accept && in_count != 4'd0) begin
            value_reg <= in_value;
            count_reg <= in_count;
            last_reg  <= in_last;
        end else if (xfer) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == EMIT);
    assign out_data  = value_reg;
    assign out_last  = (state_reg == EMIT) && last_reg && (count_reg == 4'd1);
    assign done      = (state_reg == DONE);

`ifdef RUN_EXPANDER_PACK_EN
    localparam logic [7:0] N_LEN = 8'(N);

    logic       frame_start_reg;
    logic [7:0] len_reg;
    logic       overflow_reg;
    logic       clear;

    // Buffer contents survive past done and are wiped only when the next frame's first pair arrives.
    assign clear = accept && frame_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_reg <= 1'b1;
            len_reg         <= 8'd0;
            overflow_reg    <= 1'b0;
        end else begin
            if (state_reg == DONE) begin
                frame_start_reg <= 1'b1;
            end else if (accept) begin
                frame_start_reg <= 1'b0;
            end
            if (clear) begin
                len_reg      <= 8'd0;
                overflow_reg <= 1'b0;
            end else if (xfer) begin
                if (len_reg < N_LEN) begin
                    len_reg <= len_reg + 8'd1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        logic [7:0] byte_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                byte_reg <= 8'd0;
            end else if (clear) begin
                byte_reg <= 8'd0;
            end else if (xfer && len_reg == 8'(gi)) begin
                byte_reg <= value_reg;
            end
        end
        assign out_arr[8*gi +: 8] = byte_reg;
    end

    assign out_len  = len_reg;
    assign overflow = overflow_reg;
`else
    assign out_arr  = '0;
    assign out_len  = 8'd0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_run_expander.sv
// Directed bench for run_expander (N=8); buffer expectations follow RUN_EXPANDER_PACK_EN.
module tb_run_expander;

`ifdef RUN_EXPANDER_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_value;
    logic [3:0]  in_count;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [63:0] out_arr;
    logic [7:0]  out_len;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    run_expander #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_count (in_count),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_arr  (out_arr),
        .out_len  (out_len),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; offers one pair, returns at the negedge after acceptance.
    task automatic send(input logic [7:0] v, input logic [3:0] c, input logic l);
        chk("in_ready_before_send", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_value = v;
        in_count = c;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("pair value=%0h count=%0d last=%0b", v, c, l);
    endtask

    // Waits (bounded) for out_valid, checks the byte, lets it transfer with out_ready=1.
    task automatic expect_byte(input logic [7:0] d, input logic l);
        int w = 0;
        out_ready = 1'b1;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        chk("out_data", {56'd0, out_data}, {56'd0, d});
        chk("out_last", {63'd0, out_last}, {63'd0, l});
        $display("byte data=%0h last=%0b", out_data, out_last);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 8'd0;
        in_count  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_arr", out_arr, 64'd0);
        chk("rst_out_len", {56'd0, out_len}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic frame of five runs filling the buffer exactly.
        send(8'h10, 4'd2, 1'b0);
        expect_byte(8'h10, 1'b0);
        expect_byte(8'h10, 1'b0);
        send(8'h20, 4'd2, 1'b0);
        expect_byte(8'h20, 1'b0);
        expect_byte(8'h20, 1'b0);
        send(8'h30, 4'd1, 1'b0);
        expect_byte(8'h30, 1'b0);
        send(8'h40, 4'd2, 1'b0);
        expect_byte(8'h40, 1'b0);
        expect_byte(8'h40, 1'b0);
        send(8'h50, 4'd1, 1'b1);
        expect_byte(8'h50, 1'b1);
        chk("f1_done", {63'd0, done}, 64'd1);
        chk("f1_in_ready_in_done", {63'd0, in_ready}, 64'd0);
        chk("f1_out_len", {56'd0, out_len}, PACK ? 64'd8 : 64'd0);
        chk("f1_out_arr", out_arr, PACK ? 64'h5040403020201010 : 64'd0);
        chk("f1_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("f1_done_one_cycle", {63'd0, done}, 64'd0);
        chk("f1_len_held", {56'd0, out_len}, PACK ? 64'd8 : 64'd0);

        // Backpressure: out_ready pattern 1,0,0,1,1.
        send(8'hA5, 4'd3, 1'b1);
        chk("f2_len_cleared", {56'd0, out_len}, 64'd0);
        chk("f2_arr_cleared", out_arr, 64'd0);
        out_ready = 1'b1;
        chk("f2_c1_valid", {63'd0, out_valid}, 64'd1);
        chk("f2_c1_data", {56'd0, out_data}, 64'hA5);
        chk("f2_c1_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("f2_stall_valid", {63'd0, out_valid}, 64'd1);
            chk("f2_stall_data", {56'd0, out_data}, 64'hA5);
            chk("f2_stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("f2_c4_last", {63'd0, out_last}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("f2_c5_data", {56'd0, out_data}, 64'hA5);
        chk("f2_c5_last", {63'd0, out_last}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("f2_done", {63'd0, done}, 64'd1);
        chk("f2_out_valid_off", {63'd0, out_valid}, 64'd0);
        chk("f2_out_len", {56'd0, out_len}, PACK ? 64'd3 : 64'd0);
        chk("f2_out_arr", out_arr, PACK ? 64'h0000000000A5A5A5 : 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("f2_in_ready_after", {63'd0, in_ready}, 64'd1);

        // Zero-count pairs.
        send(8'h11, 4'd0, 1'b0);
        chk("f3_zero_no_valid", {63'd0, out_valid}, 64'd0);
        chk("f3_zero_no_done", {63'd0, done}, 64'd0);
        send(8'h22, 4'd1, 1'b0);
        expect_byte(8'h22, 1'b0);
        send(8'h33, 4'd0, 1'b1);
        chk("f3_done", {63'd0, done}, 64'd1);
        chk("f3_out_valid", {63'd0, out_valid}, 64'd0);
        chk("f3_out_len", {56'd0, out_len}, PACK ? 64'd1 : 64'd0);
        chk("f3_out_arr", out_arr, PACK ? 64'h22 : 64'd0);
        @(posedge clk);
        @(negedge clk);

        // Overflow: ten bytes into an eight-byte buffer.
        send(8'hAA, 4'd5, 1'b0);
        for (int i = 0; i < 5; i++) expect_byte(8'hAA, 1'b0);
        send(8'hBB, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) expect_byte(8'hBB, 1'b0);
        chk("f4_pre_overflow", {63'd0, overflow}, 64'd1 & {63'd0, PACK});
        expect_byte(8'hBB, 1'b1);
        chk("f4_done", {63'd0, done}, 64'd1);
        chk("f4_out_len", {56'd0, out_len}, PACK ? 64'd8 : 64'd0);
        chk("f4_out_arr", out_arr, PACK ? 64'hBBBBBBAAAAAAAAAA : 64'd0);
        chk("f4_overflow", {63'd0, overflow}, PACK ? 64'd1 : 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("f4_overflow_held", {63'd0, overflow}, PACK ? 64'd1 : 64'd0);

        // Asynchronous reset in the middle of a run.
        send(8'hCC, 4'd6, 1'b0);
        expect_byte(8'hCC, 1'b0);
        expect_byte(8'hCC, 1'b0);
        chk("f5_pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("f5_pre_rst_len", {56'd0, out_len}, PACK ? 64'd2 : 64'd0);
        rst_n = 1'b0;
        #1;
        chk("f5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("f5_rst_len", {56'd0, out_len}, 64'd0);
        chk("f5_rst_arr", out_arr, 64'd0);
        chk("f5_rst_data", {56'd0, out_data}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("f5_in_ready", {63'd0, in_ready}, 64'd1);
        send(8'hDD, 4'd1, 1'b1);
        expect_byte(8'hDD, 1'b1);
        chk("f5_done", {63'd0, done}, 64'd1);
        chk("f5_out_len", {56'd0, out_len}, PACK ? 64'd1 : 64'd0);
        chk("f5_out_arr", out_arr, PACK ? 64'hDD : 64'd0);
        chk("f5_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("f5_idle_valid", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_expander.md
RUN_EXPANDER -- requirements
Module: run_expander

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the maximum number of bytes held in the packed frame buffer (1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  run pair offered.
REQ-005 The block SHALL have port in_ready  output  1  run pair accepted when high with in_valid.
REQ-006 The block SHALL have port in_value  input  8  byte value of the run.
REQ-007 The block SHALL have port in_count  input  4  repeat count of the run (0..15).
REQ-008 The block SHALL have port in_last  input  1  marks the final pair of a frame.
REQ-009 The block SHALL have port out_valid  output  1  output byte present.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the byte when high with out_valid.
REQ-011 The block SHALL have port out_data  output  8  expanded byte.
REQ-012 The block SHALL have port out_last  output  1  high on the final byte of a frame.
REQ-013 The block SHALL have port out_arr  output  8*N  packed frame buffer; element i at bits [8*(i+1)-1 -: 8].
REQ-014 The block SHALL have port out_len  output  8  number of bytes stored in out_arr.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-016 The block SHALL have port overflow  output  1  frame produced more than N bytes.

Function
REQ-017 The FSM SHALL have states IDLE, EMIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Accepting a pair with in_count>0 SHALL latch value, count and last, and move IDLE->EMIT; out_valid SHALL rise the next cycle (latency 1).
REQ-019 In EMIT, out_valid=1 and out_data=latched value; each out_valid&out_ready transfer SHALL decrement the remaining count; while out_ready=0, out_data SHALL be held.
REQ-020 On the transfer of the last byte of a run: EMIT->DONE if latched last=1, else EMIT->IDLE.
REQ-021 out_last SHALL be 1 only while emitting the final byte of a run whose latched last=1.
REQ-022 A pair with in_count=0 SHALL be consumed without emitting; with in_last=1 it SHALL go IDLE->DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 Each transferred byte SHALL be written into out_arr at index out_len, and out_len SHALL increment, while out_len<N.
REQ-025 Transfers occurring when out_len=N SHALL still be streamed but not stored; overflow SHALL be set and held.
REQ-026 out_arr, out_len and overflow SHALL remain stable from done until the first pair of the next frame is accepted, at which point they SHALL clear to 0 in the same cycle as acceptance.

Reset
REQ-027 On rst_n=0 the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-028 Reset values: in_ready=1 (after reset is released), out_valid=0, out_data=0, out_last=0, out_arr=0, out_len=0, done=0, overflow=0.
REQ-029 Reset mid-run SHALL discard the remaining count and the partially filled buffer.

Configuration
REQ-030 With macro RUN_EXPANDER_PACK_EN defined, out_arr, out_len and overflow SHALL behave as described in REQ-024..REQ-026.
REQ-031 Without RUN_EXPANDER_PACK_EN, the buffer logic SHALL be omitted; out_arr, out_len and overflow SHALL be tied to 0, and streaming and done behaviour SHALL be unchanged.

Verification
REQ-032 Pairs (10,2)(20,2)(30,1)(40,2)(50,1,last), out_ready=1 -> stream 10 10 20 20 30 40 40 50 with out_last on 50; done=1; out_len=8; out_arr={50,40,40,30,20,20,10,10} (MSB first); overflow=0.
REQ-033 Pair (A5,3,last) with out_ready toggling 1,0,0,1,1 -> three A5 transfers, out_data held while stalled, in_ready=0 until done.
REQ-034 Pairs (11,0)(22,1)(33,0,last) -> single byte 22 with out_last=0; done pulses after (33,0,last) is consumed; out_len=1.
REQ-035 Pairs (AA,5)(BB,5,last), N=8 -> 10 bytes streamed; out_arr holds AA x5 then BB x3; out_len=8; overflow=1.
REQ-036 rst_n low for 1 cycle after the 2nd byte of (CC,6) -> out_valid=0 immediately; out_len=0; a new pair (DD,1,last) then yields a single byte DD and done.
REQ-037 The bench SHALL repeat REQ-032 without RUN_EXPANDER_PACK_EN -> same stream; out_arr=0, out_len=0, overflow=0.
